// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: Diff = A - B - Bin, DIGIT bits per clock, LSB first.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the registered signed-overflow output Ovf.
module serial_subtractor #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Borrow
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   ,
   output logic             Ovf
`endif
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_bad_cfg
      $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
   end

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             brw_q, brw_d;
   logic             borrow_q, borrow_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [DIGIT-1:0] dig;
   logic [WIDTH-1:0] slice_w;
   logic [WIDTH-1:0] shifted;
   logic             c;
   logic             bo;
   logic             last;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic am_q, am_d;
   logic bm_q, bm_d;
   logic ovf_q, ovf_d;
`endif

   // Ripple of DIGIT full-subtractor cells fed by the stored borrow
   always_comb begin
      dig = '0;
      c   = brw_q;
      for (int i = 0; i < DIGIT; i++) begin
         dig[i] = a_q[i] ^ b_q[i] ^ c;
         c      = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & c);
      end
      bo = c;
      slice_w = '0;
      slice_w[DIGIT-1:0] = dig;
      shifted = (res_q >> DIGIT) | (slice_w << (WIDTH - DIGIT));
      last = (cnt_q == CW'(N - 1));
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      brw_d    = brw_q;
      borrow_d = borrow_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      am_d  = am_q;
      bm_d  = bm_q;
      ovf_d = ovf_q;
`endif
      case (state_q)
         RUN: begin
            a_d   = a_q >> DIGIT;
            b_d   = b_q >> DIGIT;
            res_d = shifted;
            brw_d = bo;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
               state_d  = DONE;
               diff_d   = shifted;
               borrow_d = bo;
               done_d   = 1'b1;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
               ovf_d = (am_q ^ bm_q) & (am_q ^ shifted[WIDTH-1]);
`endif
            end else begin
               busy_d = 1'b1;
            end
         end
         default: begin
            // IDLE and DONE both accept a new request
            if (start) begin
               state_d = RUN;
               a_d     = A;
               b_d     = B;
               brw_d   = Bin;
               res_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
               am_d = A[WIDTH-1];
               bm_d = B[WIDTH-1];
`endif
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         brw_q    <= 1'b0;
         borrow_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         am_q  <= 1'b0;
         bm_q  <= 1'b0;
         ovf_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         brw_q    <= brw_d;
         borrow_q <= borrow_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         am_q  <= am_d;
         bm_q  <= bm_d;
         ovf_q <= ovf_d;
`endif
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign Diff   = diff_q;
   assign Borrow = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor over several WIDTH/DIGIT builds.
// Instances: 0=W8D1, 1=W16D4, 2=W8D2, 3=W8D8, 4=W8D4.
module tb_serial_subtractor;

   logic        clk;
   logic        rst_n;
   logic [4:0]  start_v;
   logic [15:0] a_in;
   logic [15:0] b_in;
   logic        bin_in;
   logic [4:0]  busy_v;
   logic [4:0]  done_v;
   logic [4:0]  brw_v;
   logic [7:0]  d0, d2, d3, d4;
   logic [15:0] d1;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic [4:0]  ovf_v;
`endif

   int n_tests;
   int n_fail;
   int n_start;
   int n_done;
   int nn[5] = '{8, 4, 4, 1, 2};
   int wn[5] = '{8, 16, 8, 8, 8};
   logic [15:0] last_d[5];

   serial_subtractor #(.WIDTH(8), .DIGIT(1)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]),
      .A(a_in[7:0]), .B(b_in[7:0]), .Bin(bin_in),
      .busy(busy_v[0]), .done(done_v[0]),
      .Diff(d0), .Borrow(brw_v[0])
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      , .Ovf(ovf_v[0])
`endif
   );

   serial_subtractor #(.WIDTH(16), .DIGIT(4)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]),
      .A(a_in), .B(b_in), .Bin(bin_in),
      .busy(busy_v[1]), .done(done_v[1]),
      .Diff(d1), .Borrow(brw_v[1])
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      , .Ovf(ovf_v[1])
`endif
   );

   serial_subtractor #(.WIDTH(8), .DIGIT(2)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]),
      .A(a_in[7:0]), .B(b_in[7:0]), .Bin(bin_in),
      .busy(busy_v[2]), .done(done_v[2]),
      .Diff(d2), .Borrow(brw_v[2])
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      , .Ovf(ovf_v[2])
`endif
   );

   serial_subtractor #(.WIDTH(8), .DIGIT(8)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start_v[3]),
      .A(a_in[7:0]), .B(b_in[7:0]), .Bin(bin_in),
      .busy(busy_v[3]), .done(done_v[3]),
      .Diff(d3), .Borrow(brw_v[3])
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      , .Ovf(ovf_v[3])
`endif
   );

   serial_subtractor #(.WIDTH(8), .DIGIT(4)) u4 (
      .clk(clk), .rst_n(rst_n), .start(start_v[4]),
      .A(a_in[7:0]), .B(b_in[7:0]), .Bin(bin_in),
      .busy(busy_v[4]), .done(done_v[4]),
      .Diff(d4), .Borrow(brw_v[4])
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      , .Ovf(ovf_v[4])
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] diff_of(input int idx);
      case (idx)
         0:       return {8'h00, d0};
         1:       return d1;
         2:       return {8'h00, d2};
         3:       return {8'h00, d3};
         default: return {8'h00, d4};
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at the negedge just after the accepting edge
   task automatic wait_done(input int idx, output int cyc, output int bcnt);
      cyc  = 0;
      bcnt = 0;
      while (done_v[idx] !== 1'b1 && cyc < 64) begin
         if (busy_v[idx] === 1'b1) bcnt++;
         @(negedge clk);
         cyc++;
      end
      check("done_seen", {31'd0, done_v[idx]}, 32'd1);
      if (done_v[idx] === 1'b1) n_done++;
   endtask

   task automatic check_result(input int idx, input logic [15:0] a,
                               input logic [15:0] b, input logic bin);
      logic [16:0] full;
      logic [15:0] mask;
      logic [15:0] exp_d;
      logic        exp_b;
      int          m;
      mask  = (wn[idx] == 8) ? 16'h00FF : 16'hFFFF;
      full  = {1'b0, a & mask} - {1'b0, b & mask} - {16'd0, bin};
      exp_d = full[15:0] & mask;
      exp_b = ({1'b0, a & mask}) < ({1'b0, b & mask} + {16'd0, bin});
      check($sformatf("diff%0d", idx), {16'd0, diff_of(idx)}, {16'd0, exp_d});
      check($sformatf("borrow%0d", idx), {31'd0, brw_v[idx]}, {31'd0, exp_b});
      m = wn[idx] - 1;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      check($sformatf("ovf%0d", idx), {31'd0, ovf_v[idx]},
            {31'd0, (a[m] ^ b[m]) & (a[m] ^ exp_d[m])});
`else
      if (m < 0) $display("bad width");
`endif
      last_d[idx] = exp_d;
   endtask

   task automatic run_op(input int idx, input logic [15:0] a,
                         input logic [15:0] b, input logic bin,
                         input int gap);
      int cyc, bcnt;
      repeat (gap) @(negedge clk);
      start_v[idx] = 1'b1;
      a_in = a;
      b_in = b;
      bin_in = bin;
      n_start++;
      @(negedge clk);
      start_v[idx] = 1'b0;
      a_in = ~a;
      b_in = ~b;
      bin_in = ~bin;
      check("hold", {16'd0, diff_of(idx)}, {16'd0, last_d[idx]});
      wait_done(idx, cyc, bcnt);
      check("busy_cycles", bcnt, nn[idx]);
      check("latency", cyc, nn[idx]);
      check_result(idx, a, b, bin);
      @(negedge clk);
      check("done_pulse", {31'd0, done_v[idx]}, 32'd0);
   endtask

   initial begin
      int cyc, bcnt, cnt;
      logic [15:0] ra, rb;
      logic        rbin;
      int sweep[4] = '{0, 2, 4, 3};
      n_tests = 0;
      n_fail  = 0;
      n_start = 0;
      n_done  = 0;
      rst_n   = 1'b0;
      start_v = '0;
      a_in    = '0;
      b_in    = '0;
      bin_in  = 1'b0;
      for (int i = 0; i < 5; i++) last_d[i] = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", {27'd0, busy_v}, 32'd0);
      check("rst_done", {27'd0, done_v}, 32'd0);
      check("rst_diff0", {24'd0, d0}, 32'd0);
      check("rst_brw", {27'd0, brw_v}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(0, 16'h5A, 16'h23, 1'b0, 0);
      run_op(0, 16'h00, 16'h01, 1'b1, 1);
      run_op(0, 16'h80, 16'h01, 1'b0, 0);
      run_op(3, 16'h05, 16'h07, 1'b1, 0);

      // Start pulse and operand changes during RUN must be ignored
      start_v[1] = 1'b1;
      a_in = 16'h1234;
      b_in = 16'h1234;
      bin_in = 1'b0;
      n_start++;
      @(negedge clk);
      start_v[1] = 1'b0;
      @(negedge clk);
      start_v[1] = 1'b1;
      a_in = 16'hFFFF;
      b_in = 16'h0001;
      @(negedge clk);
      start_v[1] = 1'b0;
      wait_done(1, cyc, bcnt);
      check("u1_latency", cyc, 2);
      check_result(1, 16'h1234, 16'h1234, 1'b0);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done_v[1] === 1'b1) cnt++;
      end
      check("u1_no_extra_done", cnt, 0);

      // Back-to-back with start held in DONE
      start_v[2] = 1'b1;
      a_in = 16'h10;
      b_in = 16'h20;
      bin_in = 1'b0;
      n_start++;
      @(negedge clk);
      start_v[2] = 1'b0;
      wait_done(2, cyc, bcnt);
      check_result(2, 16'h10, 16'h20, 1'b0);
      start_v[2] = 1'b1;
      a_in = 16'hFF;
      b_in = 16'h01;
      n_start++;
      @(negedge clk);
      start_v[2] = 1'b0;
      check("b2b_busy", {31'd0, busy_v[2]}, 32'd1);
      wait_done(2, cyc, bcnt);
      check("b2b_spacing", cyc + 1, 5);
      check_result(2, 16'hFF, 16'h01, 1'b0);
      @(negedge clk);

      // Asynchronous reset on the third RUN cycle
      start_v[0] = 1'b1;
      a_in = 16'h33;
      b_in = 16'h11;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("arst_busy", {31'd0, busy_v[0]}, 32'd0);
      check("arst_done", {31'd0, done_v[0]}, 32'd0);
      check("arst_diff", {24'd0, d0}, 32'd0);
      check("arst_brw", {31'd0, brw_v[0]}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) last_d[i] = '0;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) cnt++;
      end
      check("arst_idle", cnt, 0);

      n_start = 0;
      n_done  = 0;
      foreach (sweep[s]) begin
         for (int k = 0; k < 60; k++) begin
            ra   = 16'($urandom_range(0, 255));
            rb   = 16'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            run_op(sweep[s], ra, rb, rbin, $urandom_range(0, 3));
         end
      end
      check("done_count", n_done, n_start);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
